// File: rtl/event_wait_unit.sv
// event_wait_unit: synchronises an asynchronous single-bit signal, detects its
// selected edges and counts them until a programmed target is reached or a
// cycle timeout expires. Reports busy / done / matched / timed_out status.
// Optional feature macro: EVENT_WAIT_ABORT_EN (adds an `abort` input that ends
// an armed wait early with neither matched nor timed_out set).
module event_wait_unit #(
  parameter int CNT_W       = 4,
  parameter int TMO_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] target,
  input  logic [TMO_W-1:0] timeout,
  input  logic [1:0]       edge_sel,
  input  logic             sig_in,
`ifdef EVENT_WAIT_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic             matched,
  output logic             timed_out,
  output logic [CNT_W-1:0] count,
  output logic             edge_pulse
);

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, DONE = 2'd2} state_t;

  state_t                 state;
  state_t                 state_nxt;

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic                   s_d;
  logic                   rise;
  logic                   fall;
  logic                   qual;

  logic [CNT_W-1:0]       target_l;
  logic [TMO_W-1:0]       timeout_l;
  logic [1:0]             sel_l;
  logic [TMO_W-1:0]       timer;
  logic [TMO_W-1:0]       timer_nxt;
  logic [CNT_W-1:0]       count_nxt;
  logic                   hit_match;
  logic                   hit_tmo;
  logic                   hit_abort;

  assign s    = sync[SYNC_STAGES-1];
  assign rise = s & ~s_d;
  assign fall = ~s & s_d;

  // Edges that count toward the target use the edge select latched at start.
  assign qual      = (rise & sel_l[0]) | (fall & sel_l[1]);
  assign timer_nxt = timer + {{(TMO_W-1){1'b0}}, 1'b1};
  assign count_nxt = count + {{(CNT_W-1){1'b0}}, qual};

  // Match has priority over timeout; both have priority over abort.
  assign hit_match = (count_nxt == target_l);
  assign hit_tmo   = (timeout_l != '0) && (timer_nxt == timeout_l) && !hit_match;
`ifdef EVENT_WAIT_ABORT_EN
  assign hit_abort = abort && !hit_match && !hit_tmo;
`else
  assign hit_abort = 1'b0;
`endif

  // Synchroniser chain, one-cycle delayed copy and the free-running edge pulse
  // (which follows the live edge_sel so it is observable in every state).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync       <= '0;
      s_d        <= 1'b0;
      edge_pulse <= 1'b0;
    end else begin
      if (SYNC_STAGES > 1) sync <= {sync[SYNC_STAGES-2:0], sig_in};
      else                 sync <= sig_in;
      s_d        <= s;
      edge_pulse <= (rise & edge_sel[0]) | (fall & edge_sel[1]);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state logic; start is only honoured in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ARMED;
      ARMED:   if (hit_match || hit_tmo || hit_abort) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: busy while armed, done for the single DONE cycle.
  always_comb begin
    busy = (state == ARMED);
    done = (state == DONE);
  end

  // Operation datapath: latch configuration on an accepted start, then run
  // the timer and edge counter while armed. Status holds until the next start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target_l  <= '0;
      timeout_l <= '0;
      sel_l     <= 2'b00;
      timer     <= '0;
      count     <= '0;
      matched   <= 1'b0;
      timed_out <= 1'b0;
    end else if (state == IDLE && start) begin
      target_l  <= target;
      timeout_l <= timeout;
      sel_l     <= edge_sel;
      timer     <= '0;
      count     <= '0;
      matched   <= 1'b0;
      timed_out <= 1'b0;
    end else if (state == ARMED) begin
      timer <= timer_nxt;
      count <= count_nxt;
      if (hit_match)    matched   <= 1'b1;
      else if (hit_tmo) timed_out <= 1'b1;
    end
  end

endmodule

// File: tb/tb_event_wait_unit.sv
// Directed bench for event_wait_unit: a per-cycle vector table covering the
// rising-edge match, live edge_pulse in IDLE, target=0 and match-vs-timeout
// priority, followed by hand-written multi-cycle sequences.
module tb_event_wait_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] target = '0;
  logic [7:0] timeout = '0;
  logic [1:0] edge_sel = '0;
  logic       sig_in = 1'b0;
  logic       abort = 1'b0;
  logic       busy, done, matched, timed_out, edge_pulse;
  logic [3:0] count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  event_wait_unit #(.CNT_W(4), .TMO_W(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .target(target),
    .timeout(timeout), .edge_sel(edge_sel), .sig_in(sig_in),
`ifdef EVENT_WAIT_ABORT_EN
    .abort(abort),
`endif
    .busy(busy), .done(done), .matched(matched), .timed_out(timed_out),
    .count(count), .edge_pulse(edge_pulse)
  );

  typedef struct {
    logic       start;
    logic [3:0] target;
    logic [7:0] timeout;
    logic [1:0] sel;
    logic       sig;
    logic       busy;
    logic       done;
    logic       matched;
    logic       timed_out;
    logic [3:0] count;
    logic       ep;
  } vec_t;

  vec_t tbl[25];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // start tgt  tmo  sel    sig | busy done m  t  cnt ep
    tbl[0]  = '{1'b1, 4'd2, 8'd0, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0};
    tbl[1]  = '{1'b0, 4'd2, 8'd0, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0};
    tbl[2]  = '{1'b0, 4'd2, 8'd0, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0};
    tbl[3]  = '{1'b0, 4'd2, 8'd0, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 1'b1};
    tbl[4]  = '{1'b0, 4'd2, 8'd0, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0};
    tbl[5]  = '{1'b0, 4'd2, 8'd0, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0};
    tbl[6]  = '{1'b0, 4'd2, 8'd0, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0};
    tbl[7]  = '{1'b0, 4'd2, 8'd0, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0};
    tbl[8]  = '{1'b0, 4'd2, 8'd0, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0};
    tbl[9]  = '{1'b0, 4'd2, 8'd0, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0};
    tbl[10] = '{1'b0, 4'd2, 8'd0, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd2, 1'b1};
    tbl[11] = '{1'b1, 4'd2, 8'd0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 1'b0};
    tbl[12] = '{1'b0, 4'd2, 8'd0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 1'b0};
    tbl[13] = '{1'b0, 4'd2, 8'd0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 1'b0};
    tbl[14] = '{1'b0, 4'd2, 8'd0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 1'b0};
    tbl[15] = '{1'b0, 4'd2, 8'd0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 1'b1};
    tbl[16] = '{1'b1, 4'd0, 8'd0, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0};
    tbl[17] = '{1'b0, 4'd0, 8'd0, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0};
    tbl[18] = '{1'b0, 4'd0, 8'd0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0};
    tbl[19] = '{1'b1, 4'd1, 8'd4, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0};
    tbl[20] = '{1'b0, 4'd1, 8'd4, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0};
    tbl[21] = '{1'b0, 4'd1, 8'd4, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0};
    tbl[22] = '{1'b0, 4'd1, 8'd4, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0};
    tbl[23] = '{1'b0, 4'd1, 8'd4, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 1'b1};
    tbl[24] = '{1'b0, 4'd1, 8'd4, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 1'b0};

    // Reset held while sig_in toggles: everything must stay quiet.
    #2;
    for (int i = 0; i < 6; i++) begin
      sig_in = ~sig_in;
      step(1);
      chk("rst_outs", {26'd0, busy, done, matched, timed_out, count, edge_pulse}, 32'd0);
    end
    sig_in = 1'b0;
    #3 rst_n = 1'b1;
    step(4);
    chk("rst_release_busy", {31'd0, busy}, 32'd0);
    chk("rst_release_ep", {31'd0, edge_pulse}, 32'd0);

    // Per-cycle vector table.
    for (int i = 0; i < 25; i++) begin
      start    = tbl[i].start;
      target   = tbl[i].target;
      timeout  = tbl[i].timeout;
      edge_sel = tbl[i].sel;
      sig_in   = tbl[i].sig;
      step(1);
      chk($sformatf("v%0d_busy", i), {31'd0, busy}, {31'd0, tbl[i].busy});
      chk($sformatf("v%0d_done", i), {31'd0, done}, {31'd0, tbl[i].done});
      chk($sformatf("v%0d_matched", i), {31'd0, matched}, {31'd0, tbl[i].matched});
      chk($sformatf("v%0d_timed_out", i), {31'd0, timed_out}, {31'd0, tbl[i].timed_out});
      chk($sformatf("v%0d_count", i), {28'd0, count}, {28'd0, tbl[i].count});
      chk($sformatf("v%0d_edge_pulse", i), {31'd0, edge_pulse}, {31'd0, tbl[i].ep});
    end
    start = 1'b0;

    // Timeout: one falling edge only, done 10 cycles after start accept.
    begin
      int n;
      start = 1'b1; target = 4'd3; timeout = 8'd10; edge_sel = 2'b10; sig_in = 1'b1;
      step(1);
      start = 1'b0; sig_in = 1'b0;
      n = 0;
      for (int k = 1; k <= 30; k++) begin
        step(1);
        if (done) begin n = k; break; end
      end
      chk("tmo_latency", n, 32'd10);
      chk("tmo_timed_out", {31'd0, timed_out}, 32'd1);
      chk("tmo_matched", {31'd0, matched}, 32'd0);
      chk("tmo_count", {28'd0, count}, 32'd1);
      chk("tmo_busy", {31'd0, busy}, 32'd0);
      step(1);
    end

    // Both edges, start mid-operation ignored, match after 4th edge.
    begin
      int n;
      start = 1'b1; target = 4'd4; timeout = 8'd0; edge_sel = 2'b11;
      step(1);
      start = 1'b0;
      for (int k = 0; k < 3; k++) begin
        sig_in = ~sig_in;
        step(5);
        if (k == 1) begin
          start = 1'b1; target = 4'd1; timeout = 8'd3;
          step(1);
          start = 1'b0;
          chk("both_start_ignored_busy", {31'd0, busy}, 32'd1);
          chk("both_start_ignored_count", {28'd0, count}, 32'd2);
        end
      end
      chk("both_count3", {28'd0, count}, 32'd3);
      chk("both_busy3", {31'd0, busy}, 32'd1);
      sig_in = ~sig_in;
      n = 0;
      for (int k = 1; k <= 10; k++) begin
        step(1);
        if (done) begin n = k; break; end
      end
      chk("both_done_latency", n, 32'd3);
      chk("both_count4", {28'd0, count}, 32'd4);
      chk("both_matched", {31'd0, matched}, 32'd1);
      step(1);
    end

    // Reset in the middle of an armed wait: abort without done.
    begin
      start = 1'b1; target = 4'd5; timeout = 8'd0; edge_sel = 2'b01;
      step(1);
      start = 1'b0;
      sig_in = 1'b1;
      step(5);
      chk("midrst_pre_count", {28'd0, count}, 32'd1);
      chk("midrst_pre_busy", {31'd0, busy}, 32'd1);
      #3 rst_n = 1'b0;
      #1;
      chk("midrst_outs", {26'd0, busy, done, matched, timed_out, count, edge_pulse}, 32'd0);
      for (int k = 0; k < 3; k++) begin
        step(1);
        chk("midrst_no_done", {31'd0, done}, 32'd0);
      end
      sig_in = 1'b0;
      rst_n = 1'b1;
      step(4);
      chk("midrst_idle", {31'd0, busy}, 32'd0);
    end

`ifdef EVENT_WAIT_ABORT_EN
    // Abort after three rising edges.
    begin
      start = 1'b1; target = 4'd5; timeout = 8'd0; edge_sel = 2'b01;
      step(1);
      start = 1'b0;
      for (int k = 0; k < 6; k++) begin
        sig_in = ~sig_in;
        step(5);
      end
      chk("abort_pre_count", {28'd0, count}, 32'd3);
      abort = 1'b1;
      step(1);
      abort = 1'b0;
      chk("abort_done", {31'd0, done}, 32'd1);
      chk("abort_matched", {31'd0, matched}, 32'd0);
      chk("abort_timed_out", {31'd0, timed_out}, 32'd0);
      chk("abort_count", {28'd0, count}, 32'd3);
      step(1);
      chk("abort_idle", {30'd0, busy, done}, 32'd0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
